cpu_bus_arbiter: RTL

//  Shares one external memory bus between the CPU instruction bus (fetch) and data bus (memory stage).

---
 rtl/cpu_bus_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - shares one external memory bus between CPU fetch and data ports
//
// Purpose:
//   Grants the shared SoC bus to either the instruction (fetch) bus or the data bus,
//   muxes address/rw/wdata/request from the owner and routes ready/rdata back to it.
//   Data wins contested arbitration until STARVE_LIMIT consecutive contested data wins,
//   after which fetch is forced through. A watchdog raises a sticky fault when a grant
//   waits TIMEOUT cycles for the bus (TIMEOUT = 0 disables it).
//
// Ports:
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_ibus_request/address           fetch request and address
//   o_ibus_ready/rdata               fetch completion pulse and read data
//   i_dbus_request/rw/address/wdata  data request, direction (1 = write), address, write data
//   o_dbus_ready/rdata               data completion pulse and read data
//   o_bus_request/rw/address/wdata   shared bus request side
//   i_bus_ready/rdata                shared bus response side
//   o_grant                          debug owner: 00 none, 01 fetch, 10 data
//   o_fault                          sticky watchdog fault

module cpu_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    output logic [31:0] o_dbus_rdata,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic [1:0]  o_grant,
    output logic        o_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_I,
        S_GRANT_D,
        S_RELEASE_I,
        S_RELEASE_D
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // The watchdog counts 0..TIMEOUT-1; the fault fires on the cycle the counter sits at
    // its last value, so TIMEOUT full grant cycles elapse before o_fault is seen.
    localparam int             WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            fault_q, fault_d;
    logic            in_grant;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            wdog_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wdog_q   <= wdog_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state, starvation counter and watchdog
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            S_IDLE: begin
                if (i_ibus_request && i_dbus_request) begin
                    if (starve_q == STARVE_MAX) begin
                        state_d  = S_GRANT_I;
                        starve_d = '0;
                    end else begin
                        state_d  = S_GRANT_D;
                        starve_d = starve_q + 4'd1;
                    end
                end else if (i_dbus_request) begin
                    state_d = S_GRANT_D;
                end else if (i_ibus_request) begin
                    state_d  = S_GRANT_I;
                    starve_d = '0;
                end
            end
            // A dropped request is an abort and takes priority over a coincident ready.
            S_GRANT_I: begin
                if (!i_ibus_request)  state_d = S_IDLE;
                else if (i_bus_ready) state_d = S_RELEASE_I;
            end
            S_GRANT_D: begin
                if (!i_dbus_request)  state_d = S_IDLE;
                else if (i_bus_ready) state_d = S_RELEASE_D;
            end
            // Hold here until the owner lets go so a held request is never re-issued.
            S_RELEASE_I: if (!i_ibus_request) state_d = S_IDLE;
            S_RELEASE_D: if (!i_dbus_request) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_grant = (state_q == S_GRANT_I) || (state_q == S_GRANT_D);

    always_comb begin
        wdog_d  = '0;
        fault_d = fault_q;
        if (in_grant && (state_d == state_q)) begin
            wdog_d = (wdog_q == WD_LAST) ? wdog_q : (wdog_q + WD_W'(1));
        end
        if ((TIMEOUT != 0) && in_grant && (wdog_q == WD_LAST) && !i_bus_ready) begin
            fault_d = 1'b1;
        end
    end

    // Output mux; readies are also masked by reset so a late bus ready never leaks out.
    always_comb begin
        o_bus_request = 1'b0;
        o_bus_address = '0;
        o_bus_rw      = 1'b0;
        o_bus_wdata   = '0;
        o_ibus_ready  = 1'b0;
        o_ibus_rdata  = '0;
        o_dbus_ready  = 1'b0;
        o_dbus_rdata  = '0;
        o_grant       = 2'b00;
        case (state_q)
            S_GRANT_I: begin
                o_bus_request = i_ibus_request;
                o_bus_address = i_ibus_address;
                o_ibus_ready  = i_bus_ready & i_ibus_request & ~i_reset;
                o_ibus_rdata  = i_bus_rdata;
                o_grant       = 2'b01;
            end
            S_GRANT_D: begin
                o_bus_request = i_dbus_request;
                o_bus_address = i_dbus_address;
                o_bus_rw      = i_dbus_rw;
                o_bus_wdata   = i_dbus_wdata;
                o_dbus_ready  = i_bus_ready & i_dbus_request & ~i_reset;
                o_dbus_rdata  = i_bus_rdata;
                o_grant       = 2'b10;
            end
            S_RELEASE_I: o_grant = 2'b01;
            S_RELEASE_D: o_grant = 2'b10;
            default: ;
        endcase
    end

    assign o_fault = fault_q;

endmodule
